// File: rtl/tour_cmd_pkg.sv
// ----------------------------------------------------------------------------
// tour_cmd_pkg
// Shared types and constants for the knight's-tour command sequencer:
//   state_t      - one-hot FSM state encoding
//   OP_*/HEAD_*  - cmd_proc opcodes and compass headings
//   leg_t        - one single-axis cmd_proc command {opcode, heading, squares}
//   RESP_*_DEF   - default response bytes
//   mk_leg       - packs the three leg fields
// ----------------------------------------------------------------------------
package tour_cmd_pkg;

  // One-hot encoding so a corrupted state vector is easy to detect and recover.
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    SEND_L1 = 5'b00010,
    WAIT_L1 = 5'b00100,
    SEND_L2 = 5'b01000,
    WAIT_L2 = 5'b10000
  } state_t;

  localparam logic [3:0] OP_HORZ = 4'h4;
  localparam logic [3:0] OP_VERT = 4'h5;

  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_E = 8'hBF;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_W = 8'h3F;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] heading;
    logic [3:0] squares;
  } leg_t;

  localparam logic [7:0] RESP_DONE_DEF = 8'hA5;
  localparam logic [7:0] RESP_BUSY_DEF = 8'h5A;

  // Decode result for a move that is not exactly one-hot (reads as 16'h4000).
  localparam leg_t LEG_NULL = '{opcode: OP_HORZ, heading: 8'h00, squares: 4'h0};

  function automatic leg_t mk_leg(input logic [3:0] op, input logic [7:0] hd,
                                  input logic [3:0] sq);
    leg_t l;
    l.opcode  = op;
    l.heading = hd;
    l.squares = sq;
    return l;
  endfunction

endpackage

// File: rtl/tour_cmd_seq_if.sv
// ----------------------------------------------------------------------------
// tour_cmd_seq_if
// Command path between UART_wrapper, the tour sequencer and cmd_proc.
//   cmd_UART/cmd_rdy_UART - command from UART_wrapper
//   cmd/cmd_rdy           - muxed command presented to cmd_proc
//   clr_cmd_rdy           - cmd_proc accepted the command
//   send_resp             - cmd_proc finished executing the command
//   resp                  - response byte back to the UART
// modport master: the sequencer side; modport slave: the environment side.
// ----------------------------------------------------------------------------
interface tour_cmd_seq_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output cmd, cmd_rdy, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_cmd_seq_move_decomp.sv
// ----------------------------------------------------------------------------
// move_decomp
// Splits a one-hot knight's L-move into its horizontal and vertical legs.
//   move    in  8   one-hot move code
//   horz    out leg_t horizontal leg command
//   vert    out leg_t vertical leg command
//   illegal out 1   move is not exactly one bit set
// ----------------------------------------------------------------------------
module move_decomp
  import tour_cmd_pkg::*;
(
  input  logic [7:0] move,
  output leg_t       horz,
  output leg_t       vert,
  output logic       illegal
);

  // Move table lookup; anything not one-hot decodes to LEG_NULL and flags illegal.
  always_comb begin
    horz    = LEG_NULL;
    vert    = LEG_NULL;
    illegal = 1'b0;
    case (move)
      8'h01: begin horz = mk_leg(OP_HORZ, HEAD_E, 4'd1); vert = mk_leg(OP_VERT, HEAD_N, 4'd2); end
      8'h02: begin horz = mk_leg(OP_HORZ, HEAD_W, 4'd1); vert = mk_leg(OP_VERT, HEAD_N, 4'd2); end
      8'h04: begin horz = mk_leg(OP_HORZ, HEAD_W, 4'd2); vert = mk_leg(OP_VERT, HEAD_N, 4'd1); end
      8'h08: begin horz = mk_leg(OP_HORZ, HEAD_W, 4'd2); vert = mk_leg(OP_VERT, HEAD_S, 4'd1); end
      8'h10: begin horz = mk_leg(OP_HORZ, HEAD_W, 4'd1); vert = mk_leg(OP_VERT, HEAD_S, 4'd2); end
      8'h20: begin horz = mk_leg(OP_HORZ, HEAD_E, 4'd1); vert = mk_leg(OP_VERT, HEAD_S, 4'd2); end
      8'h40: begin horz = mk_leg(OP_HORZ, HEAD_E, 4'd2); vert = mk_leg(OP_VERT, HEAD_S, 4'd1); end
      8'h80: begin horz = mk_leg(OP_HORZ, HEAD_E, 4'd2); vert = mk_leg(OP_VERT, HEAD_N, 4'd1); end
      default: begin
        horz    = LEG_NULL;
        vert    = LEG_NULL;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// ----------------------------------------------------------------------------
// tour_cmd_seq
// Plays back a solved knight's tour as pairs of single-axis cmd_proc commands
// and multiplexes them with the UART command path.
//   clk, rst_n      system clock, synchronous active-low reset
//   start_tour      starts playback (ignored unless IDLE)
//   vert_first      latched on start; 1 = vertical leg first
//   abort           returns to UART pass-through next cycle
//   move/mv_indx    TourLogic move storage read port
//   bus             command/response path (tour_cmd_seq_if.master)
//   tour_busy       high in every non-IDLE state
//   err             sticky illegal-move flag
// ----------------------------------------------------------------------------
module tour_cmd_seq
  import tour_cmd_pkg::*;
#(
  parameter int         NUM_MOVES = 25,
  parameter int         IDX_W     = $clog2(NUM_MOVES),
  parameter logic [7:0] RESP_DONE = RESP_DONE_DEF,
  parameter logic [7:0] RESP_BUSY = RESP_BUSY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic             vert_first,
  input  logic             abort,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  tour_cmd_seq_if.master   bus,
  output logic             tour_busy,
  output logic             err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t           r_state;
  logic [IDX_W-1:0] r_mv_indx;
  logic             r_err;
  logic             r_vert_first;

  leg_t w_horz;
  leg_t w_vert;
  leg_t w_leg;
  logic w_illegal;
  logic w_is_l2;
  logic w_last;

  move_decomp u_move_decomp (
    .move    (move),
    .horz    (w_horz),
    .vert    (w_vert),
    .illegal (w_illegal)
  );

  // Playback FSM; abort has priority over every handshake in a non-IDLE state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mv_indx    <= '0;
      r_err        <= 1'b0;
      r_vert_first <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_tour && !abort) begin
            r_state      <= SEND_L1;
            r_mv_indx    <= '0;
            r_err        <= 1'b0;
            r_vert_first <= vert_first;
          end else begin
            r_state <= IDLE;
          end
        end
        SEND_L1: begin
          if (abort) begin
            r_state <= IDLE;
          end else if (w_illegal) begin
            // Bad move from storage: stop the tour before any command is offered.
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (bus.clr_cmd_rdy) begin
            r_state <= WAIT_L1;
          end else begin
            r_state <= SEND_L1;
          end
        end
        WAIT_L1: begin
          if (abort)               r_state <= IDLE;
          else if (bus.send_resp)  r_state <= SEND_L2;
          else                     r_state <= WAIT_L1;
        end
        SEND_L2: begin
          if (abort)                r_state <= IDLE;
          else if (bus.clr_cmd_rdy) r_state <= WAIT_L2;
          else                      r_state <= SEND_L2;
        end
        WAIT_L2: begin
          if (abort) begin
            r_state <= IDLE;
          end else if (bus.send_resp) begin
            if (w_last) begin
              r_state <= IDLE;
            end else begin
              r_mv_indx <= r_mv_indx + IDX_ONE;
              r_state   <= SEND_L1;
            end
          end else begin
            r_state <= WAIT_L2;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Command mux and response byte, decoded from state and the current move.
  always_comb begin
    w_is_l2 = (r_state == SEND_L2) || (r_state == WAIT_L2);
    w_last  = (r_mv_indx == LAST_IDX);
    // L1 is horizontal unless vertical-first was latched; L2 is the other axis.
    w_leg   = (r_vert_first ^ w_is_l2) ? w_vert : w_horz;
    if (r_state != IDLE) begin
      bus.cmd     = w_leg;
      bus.cmd_rdy = ((r_state == SEND_L1) && !w_illegal) || (r_state == SEND_L2);
    end else begin
      bus.cmd     = bus.cmd_UART;
      bus.cmd_rdy = bus.cmd_rdy_UART;
    end
    if ((r_state == IDLE) || (w_is_l2 && w_last)) begin
      bus.resp = RESP_DONE;
    end else begin
      bus.resp = RESP_BUSY;
    end
  end

  assign mv_indx   = r_mv_indx;
  assign err       = r_err;
  assign tour_busy = (r_state != IDLE);

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
Parametrised successor to the tour command generator. After TourLogic signals completion, it plays back a solved knight's tour of NUM_MOVES moves. Each one-hot L-move is decomposed into two single-axis cmd_proc commands, and leg order is selectable. It multiplexes these commands with the UART command path ahead of cmd_proc. New relative to the prior block: parametrised tour length, vertical-first leg mode, abort, illegal-move detection with a sticky error, and a busy flag.

Parameters:
NUM_MOVES, 25, number of moves in the tour (valid 2..32)
IDX_W, $clog2(NUM_MOVES), width of mv_indx
RESP_DONE, 8'hA5, resp value when idle or on the final leg of the final move
RESP_BUSY, 8'h5A, resp value on all other tour legs

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start_tour  in  1  pulse from TourLogic done; starts playback
vert_first  in  1  sampled on start; 1 = vertical leg issued before horizontal
abort  in  1  terminates playback and returns to UART pass-through
move  in  8  one-hot move at address mv_indx
mv_indx  out  IDX_W  move address into TourLogic storage
cmd_UART  in  16  command from UART_wrapper
cmd_rdy_UART  in  1  cmd_rdy from UART_wrapper
cmd  out  16  muxed command to cmd_proc
cmd_rdy  out  1  muxed cmd_rdy to cmd_proc
clr_cmd_rdy  in  1  cmd_proc accepted the command
send_resp  in  1  cmd_proc finished executing the command
resp  out  8  response byte to UART
tour_busy  out  1  high in every non-IDLE state
err  out  1  sticky illegal-move flag

Behaviour:
- Reset: one clock, synchronous active-low (rst_n sampled on posedge clk). It forces state=IDLE, mv_indx=0, err=0 and the latched vert_first=0. It takes effect mid-tour and discards any handshake in flight.
- Outputs just after reset: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, tour_busy=0, resp=RESP_DONE.
- States: IDLE, SEND_L1, WAIT_L1, SEND_L2, WAIT_L2. Each is one-hot-safe; an illegal encoding returns to IDLE.
- IDLE:
  - start_tour && !abort → SEND_L1 next cycle.
  - On that same edge: mv_indx←0, err←0, vert_first latched.
  - start_tour in any other state is ignored.
- SEND_L1: cmd_rdy=1; clr_cmd_rdy → WAIT_L1.
- WAIT_L1: send_resp → SEND_L2.
- SEND_L2: cmd_rdy=1; clr_cmd_rdy → WAIT_L2.
- WAIT_L2, on send_resp:
  - mv_indx==NUM_MOVES-1 → IDLE, and mv_indx holds its value.
  - Otherwise mv_indx+1 and → SEND_L1.
- Mux: sel = (state != IDLE). cmd and cmd_rdy are fully combinational from state and move. cmd_rdy_SM=1 only in SEND_L1/SEND_L2. While sel=1, cmd_rdy_UART is ignored.
- Leg selection: L1 is horizontal unless vert_first is latched, in which case L1 is vertical. L2 is the other axis.
- Command encoding, cmd = {opcode[3:0], heading[7:0], squares[3:0]}:
  - Horizontal leg: opcode 4'h4; heading E=8'hBF, W=8'h3F.
  - Vertical leg: opcode 4'h5; heading N=8'h00, S=8'h7F.
- Move table, as (horizontal, vertical):
  - 01 = (E1, N2)
  - 02 = (W1, N2)
  - 04 = (W2, N1)
  - 08 = (W2, S1)
  - 10 = (W1, S2)
  - 20 = (E1, S2)
  - 40 = (E2, S1)
  - 80 = (E2, N1)
- Illegal move (not exactly one bit set), sampled in SEND_L1:
  - err←1, state→IDLE, no cmd_rdy issued.
  - err holds until the next accepted start or reset.
  - Decode output for an illegal move is 16'h4000.
- resp, combinational:
  - RESP_DONE when state==IDLE, or when state is WAIT_L2/SEND_L2 with mv_indx==NUM_MOVES-1.
  - RESP_BUSY otherwise.
  - The L1 of the last move therefore reports RESP_BUSY.
- abort:
  - In any non-IDLE state → IDLE next cycle; mv_indx holds its value; err unchanged.
  - abort beats a simultaneous clr_cmd_rdy or send_resp.
  - In IDLE, abort suppresses a same-cycle start_tour.
- clr_cmd_rdy and send_resp outside their listed states: no effect.

Decomposition:
- Package tour_cmd_pkg holds:
  - state_t enum;
  - OP_HORZ/OP_VERT and HEAD_N/E/S/W constants;
  - leg_t struct {opcode, heading, squares};
  - the RESP_DONE/RESP_BUSY defaults.
- One combinational sub-module, move_decomp:
  - input move[7:0];
  - outputs leg_t horz, leg_t vert, and illegal.
- The top level selects between the two legs with vert_first XOR (leg==2).

Test Plan:
- Reset then idle: drive cmd_UART=16'h2345 with cmd_rdy_UART=1 → cmd=16'h2345, cmd_rdy=1, resp=8'hA5, tour_busy=0.
- Horizontal-first, move=8'h01: start → cmd=16'h4BF1 with cmd_rdy=1; after clr_cmd_rdy and send_resp → cmd=16'h5002; resp=8'h5A throughout.
- vert_first=1, move=8'h08: first cmd=16'h57F1, second cmd=16'h43F2.
- Full tour with NUM_MOVES=4: exactly 8 cmd_rdy assertions; mv_indx sequence 0,1,2,3; resp becomes 8'hA5 from the L2 of move 3; final state IDLE with mv_indx=3.
- move=8'h03 at mv_indx=2 → err=1, IDLE, no cmd_rdy pulse; a later start clears err.
- Robustness cases:
  - abort asserted in the same cycle as send_resp in WAIT_L2 → IDLE, mv_indx unchanged.
  - rst_n low for one cycle mid-WAIT_L1 → IDLE, mv_indx=0.
  - rst_n low with no clock edge → no change.
